// File: rtl/mem_bist_pkg.sv
// Shared definitions for the March C- memory BIST: FSM encodings and the march element table.
package mem_bist_pkg;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WR       = 3'd1;
    localparam logic [2:0] RD_ISSUE = 3'd2;
    localparam logic [2:0] RD_CHECK = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    localparam int unsigned NUM_ELEM = 6;

    typedef struct packed {
        logic dir_up;
        logic has_read;
        logic read_val;
        logic has_write;
        logic write_val;
    } march_elem_t;

    // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
    function automatic march_elem_t march_elem(input logic [2:0] idx);
        march_elem_t e;
        case (idx)
            3'd0:    e = '{dir_up: 1'b1, has_read: 1'b0, read_val: 1'b0, has_write: 1'b1, write_val: 1'b0};
            3'd1:    e = '{dir_up: 1'b1, has_read: 1'b1, read_val: 1'b0, has_write: 1'b1, write_val: 1'b1};
            3'd2:    e = '{dir_up: 1'b1, has_read: 1'b1, read_val: 1'b1, has_write: 1'b1, write_val: 1'b0};
            3'd3:    e = '{dir_up: 1'b0, has_read: 1'b1, read_val: 1'b0, has_write: 1'b1, write_val: 1'b1};
            3'd4:    e = '{dir_up: 1'b0, has_read: 1'b1, read_val: 1'b1, has_write: 1'b1, write_val: 1'b0};
            default: e = '{dir_up: 1'b1, has_read: 1'b1, read_val: 1'b0, has_write: 1'b0, write_val: 1'b0};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/mem_bist_if.sv
// Synchronous memory port bundle between the BIST master and the 32x8 memory.
interface mem_bist_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 8
);
    logic          read;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;

    modport master (output read, write, addr, data_in, input data_out);
    modport slave  (input read, write, addr, data_in, output data_out);
endinterface

// File: rtl/mem_bist.sv
// March C- self-test controller: sequences the element table over the memory and
// records pass/fail, the first failing access and a saturating mismatch count.
module mem_bist
    import mem_bist_pkg::*;
#(
    parameter int unsigned   DEPTH = 32,
    parameter int unsigned   AW    = 5,
    parameter int unsigned   DW    = 8,
    parameter logic [DW-1:0] BG    = 8'h00
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [7:0]    err_cnt,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_exp,
    output logic [DW-1:0] fail_got,
    mem_bist_if.master    mem
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [2:0]    LAST_ELEM = 3'(NUM_ELEM - 1);

    logic [2:0]    state;
    logic [2:0]    elem;
    logic          at_end;
    logic          last_op;
    logic [2:0]    step_elem;
    logic [AW-1:0] step_addr;
    logic [DW-1:0] exp_rd;
    logic          mismatch;

    function automatic logic [DW-1:0] pattern(input logic v);
        return v ? ~BG : BG;
    endfunction

    // mem.addr doubles as the march address counter; terminal compare depends on direction.
    always_comb begin
        at_end    = march_elem(elem).dir_up ? (mem.addr == LAST) : (mem.addr == '0);
        last_op   = at_end && (elem == LAST_ELEM);
        step_elem = at_end ? elem + 3'd1 : elem;
        if (at_end)
            step_addr = march_elem(elem + 3'd1).dir_up ? '0 : LAST;
        else
            step_addr = march_elem(elem).dir_up ? mem.addr + 1'b1 : mem.addr - 1'b1;
        exp_rd   = pattern(march_elem(elem).read_val);
        mismatch = (mem.data_out != exp_rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            elem        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_cnt     <= '0;
            fail_addr   <= '0;
            fail_exp    <= '0;
            fail_got    <= '0;
            mem.read    <= 1'b0;
            mem.write   <= 1'b0;
            mem.addr    <= '0;
            mem.data_in <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= WR;
                        elem        <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        err_cnt     <= '0;
                        fail_addr   <= '0;
                        fail_exp    <= '0;
                        fail_got    <= '0;
                        mem.read    <= 1'b0;
                        mem.write   <= 1'b1;
                        mem.addr    <= march_elem(3'd0).dir_up ? '0 : LAST;
                        mem.data_in <= pattern(march_elem(3'd0).write_val);
                    end
                end
                WR: begin
                    // Write is always the last op at an address, so step position here.
                    elem     <= step_elem;
                    mem.addr <= step_addr;
                    if (march_elem(step_elem).has_read) begin
                        state     <= RD_ISSUE;
                        mem.write <= 1'b0;
                        mem.read  <= 1'b1;
                    end else begin
                        state       <= WR;
                        mem.write   <= 1'b1;
                        mem.data_in <= pattern(march_elem(step_elem).write_val);
                    end
                end
                RD_ISSUE: begin
                    state    <= RD_CHECK;
                    mem.read <= 1'b0;
                end
                RD_CHECK: begin
                    if (mismatch) begin
                        if (err_cnt != '1)
                            err_cnt <= err_cnt + 8'd1;
                        if (err_cnt == '0) begin
                            fail_addr <= mem.addr;
                            fail_exp  <= exp_rd;
                            fail_got  <= mem.data_out;
                        end
                    end
                    if (march_elem(elem).has_write) begin
                        state       <= WR;
                        mem.write   <= 1'b1;
                        mem.data_in <= pattern(march_elem(elem).write_val);
                    end else if (last_op) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt == '0) && !mismatch;
                    end else begin
                        elem     <= step_elem;
                        mem.addr <= step_addr;
                        if (march_elem(step_elem).has_read) begin
                            state    <= RD_ISSUE;
                            mem.read <= 1'b1;
                        end else begin
                            state       <= WR;
                            mem.write   <= 1'b1;
                            mem.data_in <= pattern(march_elem(step_elem).write_val);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem.read  <= 1'b0;
                    mem.write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bist.sv
// Scoreboard bench for mem_bist: a behavioural 32x8 memory with an optional stuck-at fault,
// expected run results and memory ops queued by the stimulus and checked by a monitor.
module tb_mem_bist;
    localparam int unsigned   DEPTH = 32;
    localparam int unsigned   AW    = 5;
    localparam int unsigned   DW    = 8;
    localparam logic [DW-1:0] BG    = 8'h00;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy, done, pass;
    logic [7:0]    err_cnt;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_exp, fail_got;
    logic          stuck;
    logic [DW-1:0] mem_arr [DEPTH];

    mem_bist_if #(.AW(AW), .DW(DW)) mif ();

    mem_bist #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .BG(BG)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got),
        .mem(mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model; the fault forces bit 0 of word 5 to read as 1.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem_arr[i] = 8'hA5;
        mif.data_out = '0;
    end
    always @(posedge clk) begin
        if (mif.write) mem_arr[mif.addr] <= mif.data_in;
        if (mif.read)
            mif.data_out <= mem_arr[mif.addr] | {7'b0, (stuck && mif.addr == 5'd5)};
    end

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct { int pass; int err; int fa; int fe; int fg; } res_t;
    typedef struct { int cyc; bit rd; bit wr; int addr; int data; } op_t;
    res_t res_q[$];
    op_t  op_q[$];

    // Monitor: per busy cycle index k, compare queued memory ops; on done rising, compare results.
    int  k = 0, bcnt = 0, overlap = 0;
    bit  prev_busy = 0, prev_done = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 0;
            prev_done = 0;
            overlap   = 0;
        end else begin
            if (busy && !prev_busy) begin
                k = 0;
                bcnt = 0;
            end
            if (mif.read && mif.write) overlap++;
            if (busy) begin
                if (op_q.size() > 0 && op_q[0].cyc == k) begin
                    op_t o;
                    o = op_q.pop_front();
                    chk($sformatf("op%0d_read", o.cyc), 32'(mif.read), 32'(o.rd));
                    chk($sformatf("op%0d_write", o.cyc), 32'(mif.write), 32'(o.wr));
                    chk($sformatf("op%0d_addr", o.cyc), 32'(mif.addr), o.addr);
                    if (o.wr) chk($sformatf("op%0d_data", o.cyc), 32'(mif.data_in), o.data);
                end
                k++;
                bcnt++;
            end
            if (done && !prev_done) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("pass", 32'(pass), r.pass);
                    chk("err_cnt", 32'(err_cnt), r.err);
                    chk("fail_addr", 32'(fail_addr), r.fa);
                    chk("fail_exp", 32'(fail_exp), r.fe);
                    chk("fail_got", 32'(fail_got), r.fg);
                    chk("busy_cycles", bcnt, 32'd480);
                    chk("busy_low_at_done", 32'(busy), 32'd0);
                    chk("rw_overlap", overlap, 32'd0);
                end
                overlap = 0;
            end
            prev_busy = busy;
            prev_done = done;
        end
    end

    task automatic push_ops();
        for (int i = 0; i < DEPTH; i++) op_q.push_back('{cyc: i, rd: 0, wr: 1, addr: i, data: int'(BG)});
        // E3 begins after E0 (32) + E1 (96) + E2 (96) cycles, reading from the top address.
        op_q.push_back('{cyc: 224, rd: 1, wr: 0, addr: 31, data: 0});
    endtask

    task automatic push_run(input int p, input int e, input int fa, input int fe, input int fg);
        res_q.push_back('{pass: p, err: e, fa: fa, fe: fe, fg: fg});
        push_ops();
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("timeout_done", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        chk({tag, "_fail"}, {8'h0, 3'h0, fail_addr, fail_exp, fail_got}, 32'd0);
        chk({tag, "_strobes"}, {30'h0, mif.read, mif.write}, 32'd0);
        chk({tag, "_addr_data"}, {19'h0, mif.addr, mif.data_in}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nz;
        rst_n = 1'b0;
        start = 1'b0;
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fault-free run
        push_run(1, 0, 0, 0, 0);
        pulse_start();
        wait_done();
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (mem_arr[i] !== BG) nz++;
        chk("mem_final_nonzero_words", nz, 32'd0);

        // Stuck-at-1 on bit 0 of word 5: r0 reads in E1, E3, E5 mismatch
        stuck = 1'b1;
        push_run(0, 3, 5, 8'h00, 8'h01);
        pulse_start();
        wait_done();

        // Restart from DONE after failure: results clear on the accepting edge
        stuck = 1'b0;
        push_run(1, 0, 0, 0, 0);
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1;
        chk("restart_err_cnt", 32'(err_cnt), 32'd0);
        chk("restart_fail", {11'h0, fail_addr, fail_exp, fail_got}, 32'd0);
        chk("restart_done_pass", {30'h0, done, pass}, 32'd0);
        chk("restart_busy_write", {30'h0, busy, mif.write}, 32'd3);
        @(negedge clk) start = 1'b0;
        wait_done();

        // start pulses while busy are ignored
        push_run(1, 0, 0, 0, 0);
        pulse_start();
        repeat (8) @(negedge clk);
        pulse_start();
        repeat (288) @(negedge clk);
        pulse_start();
        wait_done();

        // Reset mid-test aborts with everything cleared
        push_ops();
        pulse_start();
        repeat (198) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        op_q.delete();
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        push_run(1, 0, 0, 0, 0);
        pulse_start();
        wait_done();

        chk("leftover_results", res_q.size(), 32'd0);
        chk("leftover_ops", op_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_bist.md
Name: mem_bist

Overview:
- Upstream master for the 32x8 synchronous memory. Drives its read/write/addr/data_in and consumes its registered data_out.
- Runs a March C- self-test on request and reports pass/fail, first-failure details and an error count.
- Sits between the test controller (start/status) and the memory; top level wires the mem_* ports into the memory's interface instance.

Parameters:
- DEPTH, 32, number of memory words tested
- AW, 5, address width ($clog2(DEPTH))
- DW, 8, data width
- BG, 8'h00, data background; "0" pattern = BG, "1" pattern = ~BG

Ports:
- clk  in  1  clock, shared with memory
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin test; sampled only in IDLE or DONE
- busy  out  1  test in progress
- done  out  1  test finished; held until next accepted start
- pass  out  1  valid when done: 1 = zero mismatches
- err_cnt  out  8  mismatch count, saturates at 255
- fail_addr  out  AW  address of first mismatch
- fail_exp  out  DW  expected data of first mismatch
- fail_got  out  DW  read data of first mismatch
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_data_in  out  DW  memory write data
- mem_data_out  in  DW  memory registered read data

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- All outputs are registered.
- Reset values: every output 0; state IDLE.
- rst_n asserted mid-test aborts immediately. mem_read and mem_write drop asynchronously. No partial result survives.
- mem_read and mem_write are never both 1.
- March elements, in order:
  - E0 up(w0)
  - E1 up(r0,w1)
  - E2 up(r1,w0)
  - E3 down(r0,w1)
  - E4 down(r1,w0)
  - E5 up(r0)
- Up runs addr 0..DEPTH-1; down runs DEPTH-1..0.
- States:
  - IDLE: wait for start.
  - WR: mem_write=1, mem_addr=addr, mem_data_in=pattern. Used for E0 and for the write op of E1–E4.
  - RD_ISSUE: mem_read=1, mem_addr=addr.
  - RD_CHECK: both strobes 0. Compare mem_data_out against the expected pattern (memory latched it on the edge ending RD_ISSUE).
  - Then go to WR (E1–E4), or advance the address/element (E5).
  - DONE.
- Per-address cost: E0 = 1 cycle; E1–E4 = 3 cycles; E5 = 2 cycles.
- busy is high for exactly DEPTH*(1+4*3+2) = 480 cycles (DEPTH=32).
- Timing from start:
  - Edge that samples start=1: busy=1 and the first WR drive become visible.
  - done=1 and busy=0 are registered on the edge after the last RD_CHECK.
  - pass=(err_cnt==0) is set on the same edge as done.
- Mismatch in RD_CHECK:
  - err_cnt += 1, saturating at 255.
  - On the first mismatch only: capture fail_addr/fail_exp/fail_got.
  - The test continues to completion.
- Element boundary: address wraps/reloads with no idle cycle; element index increments.
- start while busy is ignored.
- start in DONE clears done, pass, err_cnt and fail_* on the accepting edge and restarts at E0.
- Address counter is AW bits with explicit terminal compare (DEPTH-1 up, 0 down); no reliance on overflow.

Decomposition:
- Package mem_bist_pkg:
  - state enum {IDLE, WR, RD_ISSUE, RD_CHECK, DONE}
  - march element table: 6 entries of {dir_up, has_read, read_val, has_write, write_val}
  - NUM_ELEM=6
- Single module. The element table drives sequencing; no sub-module needed.

Test Plan:
- Fault-free memory, BG=8'h00, start pulse:
  - busy high exactly 480 cycles.
  - done=1, pass=1, err_cnt=0.
  - Final memory contents all 8'h00.
- Protocol check over the full run:
  - Never read&&write.
  - First 32 cycles: writes of 8'h00 to addr 0..31.
  - E3 first RD_ISSUE addr=31.
- Bench forces memory[5] bit0 stuck-at-1:
  - pass=0, fail_addr=5, fail_exp=8'h00, fail_got=8'h01.
  - err_cnt=3 (mismatches in E1, E3, E5).
- rst_n low at cycle 200 of the test:
  - All outputs 0 immediately; strobes low.
  - Subsequent start gives a clean 480-cycle pass.
- start pulsed at cycles 10 and 300 while busy: ignored, single 480-cycle run.
- start while done=1 after a failing run: err_cnt/fail_* cleared on the accepting edge, new run starts.
